// File: rtl/pulse_xfer_pkg.sv
// Shared types and constants for the fast-to-slow pulse transfer transmitter.
// Holds the per-channel handshake state encoding and the pending-counter saturation helper.
package pulse_xfer_pkg;

    typedef enum logic {
        XFER_IDLE = 1'b0,
        XFER_WAIT = 1'b1
    } xfer_state_e;

    localparam int SYNC_STAGES_DEF = 2;

    function automatic int unsigned cnt_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_xfer_ch.sv
// One transmit channel: ack synchronizer, saturating pending counter, toggle req/ack handshake.
// Pulse-to-req latency is 2 edges; events queue up to cnt_max(CNT_W); optional PULSE_XFER_OVF_EN sticky drop flag.
module pulse_xfer_ch
    import pulse_xfer_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pulse_in,
    input  logic             ack_tgl,
`ifdef PULSE_XFER_OVF_EN
    input  logic             clr_ovf,
    output logic             overflow,
`endif
    output logic             req_tgl,
    output logic             busy,
    output logic [CNT_W-1:0] pending
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_req;
    logic [CNT_W-1:0]       r_cnt;

    logic        w_ack_s;
    xfer_state_e w_state;
    logic        w_launch;
    logic        w_drop;

    // The handshake state is not stored separately: a mismatch between our
    // toggle and the synchronized ack is WAIT, which also covers spurious acks.
    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    assign w_state  = xfer_state_e'(r_req ^ w_ack_s);
    assign w_launch = (w_state == XFER_IDLE) && (r_cnt != '0);
    assign w_drop   = pulse_in && !w_launch && (r_cnt == MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_req  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_tgl};
            if (w_launch) begin
                r_req <= ~r_req;
            end
            case ({w_launch, pulse_in})
                2'b10:   r_cnt <= r_cnt - CNT_W'(1);
                2'b01:   if (r_cnt != MAX) r_cnt <= r_cnt + CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef PULSE_XFER_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign overflow = r_ovf;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

    assign req_tgl = r_req;
    assign busy    = (w_state == XFER_WAIT);
    assign pending = r_cnt;

endmodule

// File: rtl/pulse_xfer_tx.sv
// Multi-channel pulse transfer transmitter: NCH independent pulse_xfer_ch lanes, pending packed per channel.
// Pulse-to-req latency 2 edges; bursts queue per channel; PULSE_XFER_OVF_EN adds overflow/clr_ovf ports.
module pulse_xfer_tx
    import pulse_xfer_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH-1:0]       pulse_in,
    input  logic [NCH-1:0]       ack_tgl,
`ifdef PULSE_XFER_OVF_EN
    input  logic                 clr_ovf,
    output logic [NCH-1:0]       overflow,
`endif
    output logic [NCH-1:0]       req_tgl,
    output logic [NCH-1:0]       busy,
    output logic [NCH*CNT_W-1:0] pending
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pulse_xfer_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .pulse_in (pulse_in[i]),
            .ack_tgl  (ack_tgl[i]),
`ifdef PULSE_XFER_OVF_EN
            .clr_ovf  (clr_ovf),
            .overflow (overflow[i]),
`endif
            .req_tgl  (req_tgl[i]),
            .busy     (busy[i]),
            .pending  (pending[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_pulse_xfer_tx.sv
// Directed bench for pulse_xfer_tx with a receiver model echoing req_tgl onto ack_tgl 6 cycles later.
module tb_pulse_xfer_tx;

    localparam int NCH   = 4;
    localparam int CNT_W = 3;

    logic                 clk      = 1'b0;
    logic                 reset_n  = 1'b0;
    logic [NCH-1:0]       pulse_in = '0;
    logic [NCH-1:0]       ack_tgl  = '0;
    logic [NCH-1:0]       req_tgl;
    logic [NCH-1:0]       busy;
    logic [NCH*CNT_W-1:0] pending;
`ifdef PULSE_XFER_OVF_EN
    logic                 clr_ovf  = 1'b0;
    logic [NCH-1:0]       overflow;
`endif

    int errors = 0;
    int checks = 0;

    pulse_xfer_tx #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pulse_in (pulse_in),
        .ack_tgl  (ack_tgl),
`ifdef PULSE_XFER_OVF_EN
        .clr_ovf  (clr_ovf),
        .overflow (overflow),
`endif
        .req_tgl  (req_tgl),
        .busy     (busy),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    // Receiver model: ack follows req 6 cycles later, 1ns after the edge.
    logic [NCH-1:0] rx_dly [7];
    bit             rx_hold = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            for (int i = 0; i < 7; i++) rx_dly[i] = '0;
            ack_tgl = '0;
        end else begin
            for (int i = 6; i > 0; i--) rx_dly[i] = rx_dly[i-1];
            rx_dly[0] = req_tgl;
            if (!rx_hold) ack_tgl = rx_dly[6];
        end
    end

    int             tog [NCH] = '{default: 0};
    logic [NCH-1:0] prev_req  = '0;
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NCH; i++) begin
            if (req_tgl[i] !== prev_req[i]) tog[i]++;
        end
        prev_req = req_tgl;
    end

    function automatic logic [CNT_W-1:0] pend(input int ch);
        return pending[ch*CNT_W +: CNT_W];
    endfunction

    task automatic wait_idle(input logic [NCH-1:0] mask, input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            bit all_zero = 1'b1;
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (mask[c] && pend(c) != '0) all_zero = 1'b0;
            end
            if (((busy & mask) == '0) && all_zero) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b pending=%h not idle within %0d cycles", name, busy, pending, budget);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (req_tgl !== '0) begin errors++; $display("FAIL reset_req: got %b expected 0", req_tgl); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
`ifdef PULSE_XFER_OVF_EN
        checks++; if (overflow !== '0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
`endif
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_tgl !== '0 || busy !== '0 || pending !== '0) begin
            errors++; $display("FAIL post_reset_idle: req=%b busy=%b pending=%h expected all 0", req_tgl, busy, pending);
        end
    endtask

    task automatic test_single(input int ch);
        int   base = tog[ch];
        logic r0   = req_tgl[ch];
        int   n    = 1;
        @(negedge clk); pulse_in[ch] = 1'b1;
        @(negedge clk); pulse_in[ch] = 1'b0;
        checks++; if (pend(ch) !== 3'd1) begin errors++; $display("FAIL single%0d_pend1: got %0d expected 1", ch, pend(ch)); end
        checks++; if (req_tgl[ch] !== r0) begin errors++; $display("FAIL single%0d_no_early_req: got %b expected %b", ch, req_tgl[ch], r0); end
        @(negedge clk);
        checks++; if (req_tgl[ch] !== ~r0) begin errors++; $display("FAIL single%0d_req_toggle: got %b expected %b", ch, req_tgl[ch], ~r0); end
        checks++; if (pend(ch) !== 3'd0) begin errors++; $display("FAIL single%0d_pend0: got %0d expected 0", ch, pend(ch)); end
        checks++; if (busy[ch] !== 1'b1) begin errors++; $display("FAIL single%0d_busy: got %b expected 1", ch, busy[ch]); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy[ch]) n++;
            else break;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL single%0d_busy_len: got %0d expected 8", ch, n); end
        checks++; if (busy[ch] !== 1'b0 || pend(ch) !== 3'd0) begin
            errors++; $display("FAIL single%0d_final_idle: busy=%b pending=%0d expected 0/0", ch, busy[ch], pend(ch));
        end
        checks++; if (tog[ch] - base != 1) begin errors++; $display("FAIL single%0d_toggles: got %0d expected 1", ch, tog[ch] - base); end
    endtask

    task automatic test_burst();
        int base = tog[1];
        int peak = 0;
        @(negedge clk); pulse_in[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (int'(pend(1)) > peak) peak = int'(pend(1));
            if (i == 4) pulse_in[1] = 1'b0;
        end
        wait_idle(4'b0010, 200, "burst");
        checks++; if (peak != 4) begin errors++; $display("FAIL burst_peak: got %0d expected 4", peak); end
        checks++; if (tog[1] - base != 5) begin errors++; $display("FAIL burst_toggles: got %0d expected 5", tog[1] - base); end
`ifdef PULSE_XFER_OVF_EN
        checks++; if (overflow !== '0) begin errors++; $display("FAIL burst_ovf: got %b expected 0", overflow); end
`endif
    endtask

    task automatic test_saturate();
        int base = tog[2];
        int mid;
        @(negedge clk); rx_hold = 1'b1; pulse_in[2] = 1'b1;
        repeat (10) @(negedge clk);
        pulse_in[2] = 1'b0;
        checks++; if (pend(2) !== 3'd7) begin errors++; $display("FAIL sat_pend: got %0d expected 7", pend(2)); end
        checks++; if (tog[2] - base != 1) begin errors++; $display("FAIL sat_first_toggle: got %0d expected 1", tog[2] - base); end
`ifdef PULSE_XFER_OVF_EN
        checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL sat_ovf_set: got %b expected 0100", overflow); end
        @(negedge clk); pulse_in[2] = 1'b1; clr_ovf = 1'b1;
        @(negedge clk); pulse_in[2] = 1'b0; clr_ovf = 1'b0;
        checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL sat_set_priority: got %b expected 0100", overflow); end
`endif
        mid = tog[2];
        rx_hold = 1'b0;
        wait_idle(4'b0100, 200, "sat");
        checks++; if (tog[2] - mid != 7) begin errors++; $display("FAIL sat_drain_toggles: got %0d expected 7", tog[2] - mid); end
`ifdef PULSE_XFER_OVF_EN
        checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL sat_ovf_sticky: got %b expected 0100", overflow); end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        checks++; if (overflow !== '0) begin errors++; $display("FAIL sat_ovf_clear: got %b expected 0", overflow); end
`endif
    endtask

    task automatic test_sat_launch();
        int base = tog[3];
        bit seen = 1'b0;
        @(negedge clk); rx_hold = 1'b1; pulse_in[3] = 1'b1;
        repeat (8) @(negedge clk);
        pulse_in[3] = 1'b0;
        checks++; if (pend(3) !== 3'd7) begin errors++; $display("FAIL satl_pend7: got %0d expected 7", pend(3)); end
        rx_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy[3]) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL satl_busy_release: busy=%b expected 0 within 20 cycles", busy[3]); end
        pulse_in[3] = 1'b1;
        @(negedge clk); pulse_in[3] = 1'b0;
        checks++; if (pend(3) !== 3'd7) begin errors++; $display("FAIL satl_net_zero: got %0d expected 7", pend(3)); end
        checks++; if (tog[3] - base != 2) begin errors++; $display("FAIL satl_launch: got %0d toggles expected 2", tog[3] - base); end
`ifdef PULSE_XFER_OVF_EN
        checks++; if (overflow !== '0) begin errors++; $display("FAIL satl_no_ovf: got %b expected 0", overflow); end
`endif
        wait_idle(4'b1000, 200, "satl");
        checks++; if (tog[3] - base != 9) begin errors++; $display("FAIL satl_total: got %0d toggles expected 9", tog[3] - base); end
    endtask

    task automatic test_all_channels();
        int             base [NCH];
        logic [NCH-1:0] r0 = req_tgl;
        for (int c = 0; c < NCH; c++) base[c] = tog[c];
        @(negedge clk); pulse_in = 4'hF;
        @(negedge clk); pulse_in = 4'h0;
        checks++; if (pending !== 12'h249) begin errors++; $display("FAIL all_pend: got %h expected 249", pending); end
        checks++; if (req_tgl !== r0) begin errors++; $display("FAIL all_no_early_req: got %b expected %b", req_tgl, r0); end
        @(negedge clk);
        checks++; if (req_tgl !== ~r0) begin errors++; $display("FAIL all_req_toggle: got %b expected %b", req_tgl, ~r0); end
        checks++; if (busy !== 4'hF || pending !== '0) begin
            errors++; $display("FAIL all_busy: busy=%b pending=%h expected 1111/000", busy, pending);
        end
        wait_idle(4'hF, 50, "all");
        for (int c = 0; c < NCH; c++) begin
            checks++; if (tog[c] - base[c] != 1) begin errors++; $display("FAIL all_toggles_ch%0d: got %0d expected 1", c, tog[c] - base[c]); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); pulse_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        pulse_in[0] = 1'b0;
        checks++; if (pend(0) !== 3'd3 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL rmid_setup: pending=%0d busy=%b expected 3/1", pend(0), busy[0]);
        end
        @(posedge clk); #2; reset_n = 1'b0;
        #1;
        checks++; if (req_tgl !== '0 || busy !== '0 || pending !== '0) begin
            errors++; $display("FAIL rmid_async_clear: req=%b busy=%b pending=%h expected all 0", req_tgl, busy, pending);
        end
`ifdef PULSE_XFER_OVF_EN
        checks++; if (overflow !== '0) begin errors++; $display("FAIL rmid_ovf: got %b expected 0", overflow); end
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_single(0);
    endtask

    initial begin
        test_reset();
        test_single(0);
        test_burst();
        test_saturate();
        test_sat_launch();
        test_all_channels();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
